// File: rtl/shift_pkg.sv
// Shared definitions for the shift/rotate execution stage: op encodings and default widths.
package shift_pkg;
    localparam int SHIFT_WIDTH = 16;
    localparam int SHIFT_CNT_W = 4;
    localparam int SHIFT_TAG_W = 3;

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_SRL = 2'b11;
endpackage

// File: rtl/shift_exec_stage_if.sv
// Issue-side and writeback-side handshake bundle of the shift execution stage.
interface shift_exec_stage_if #(
    parameter int WIDTH = shift_pkg::SHIFT_WIDTH,
    parameter int CNT_W = shift_pkg::SHIFT_CNT_W,
    parameter int TAG_W = shift_pkg::SHIFT_TAG_W
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] in_data;
    logic [CNT_W-1:0] in_cnt;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_zero;

    modport master (
        output in_valid, in_op, in_data, in_cnt, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_zero
    );
    modport slave (
        input  in_valid, in_op, in_data, in_cnt, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_zero
    );
endinterface

// File: rtl/shift_rot_core.sv
// Combinational shifter: every op is a left rotate (right ops by WIDTH-cnt) followed by a mask.
module shift_rot_core
    import shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH,
    parameter int CNT_W = SHIFT_CNT_W
) (
    input  logic [WIDTH-1:0] data,
    input  logic [1:0]       op,
    input  logic [CNT_W-1:0] cnt,
    output logic [WIDTH-1:0] result
);
    logic [CNT_W-1:0] k;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] stg [CNT_W+1];

    // Right ops use the two's complement of cnt, which is (WIDTH-cnt) mod WIDTH.
    assign k = op[1] ? (~cnt + CNT_W'(1)) : cnt;
    assign stg[0] = data;

    for (genvar i = 0; i < CNT_W; i++) begin : g_rot
        localparam int SH = 1 << i;
        assign stg[i+1] = k[i] ? {stg[i][WIDTH-SH-1:0], stg[i][WIDTH-1:WIDTH-SH]} : stg[i];
    end

    always_comb begin
        mask = '1;
        if (op == OP_SLL) mask = {WIDTH{1'b1}} << cnt;
        else if (op == OP_SRL) mask = {WIDTH{1'b1}} >> cnt;
    end

    assign result = stg[CNT_W] & mask;
endmodule

// File: rtl/shift_exec_stage.sv
// Two-stage shift/rotate unit: S1 latches the op, S2 holds the masked rotate result for writeback.
module shift_exec_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH,
    parameter int CNT_W = SHIFT_CNT_W,
    parameter int TAG_W = SHIFT_TAG_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    shift_exec_stage_if.slave  bus,
    output logic [15:0]        op_count
);
    logic             s1_valid;
    logic [1:0]       s1_op;
    logic [WIDTH-1:0] s1_data;
    logic [CNT_W-1:0] s1_cnt;
    logic [TAG_W-1:0] s1_tag;
    logic             s2_valid;
    logic [WIDTH-1:0] s2_result;
    logic [TAG_W-1:0] s2_tag;
    logic             s2_zero;
    logic [WIDTH-1:0] core_result;
    logic             s2_free;
    logic             move;
    logic             accept;

    shift_rot_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
        .data   (s1_data),
        .op     (s1_op),
        .cnt    (s1_cnt),
        .result (core_result)
    );

    assign s2_free      = !s2_valid || bus.out_ready;
    assign move         = s1_valid && s2_free;
    assign bus.in_ready = !flush && (!s1_valid || s2_free);
    assign accept       = bus.in_valid && bus.in_ready;

    assign bus.out_valid  = s2_valid;
    assign bus.out_result = s2_result;
    assign bus.out_tag    = s2_tag;
    assign bus.out_zero   = s2_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_op     <= '0;
            s1_data   <= '0;
            s1_cnt    <= '0;
            s1_tag    <= '0;
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_tag    <= '0;
            s2_zero   <= 1'b0;
        end else begin
            // Data regs load on their own strobes; flush only kills the valid bits.
            if (accept) begin
                s1_op   <= bus.in_op;
                s1_data <= bus.in_data;
                s1_cnt  <= bus.in_cnt;
                s1_tag  <= bus.in_tag;
            end
            if (move) begin
                s2_result <= core_result;
                s2_tag    <= s1_tag;
                s2_zero   <= (core_result == '0);
            end
            if (flush) begin
                s1_valid <= 1'b0;
                s2_valid <= 1'b0;
            end else begin
                if (accept) s1_valid <= 1'b1;
                else if (move) s1_valid <= 1'b0;
                if (s2_free) s2_valid <= s1_valid;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) op_count <= '0;
        else if (s2_valid && bus.out_ready) op_count <= op_count + 16'd1;
    end
endmodule

// File: tb/tb_shift_exec_stage.sv
// Directed bench for shift_exec_stage: per-op results, streaming, backpressure, flush and async reset.
module tb_shift_exec_stage;
    import shift_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [15:0] op_count;
    int          n_chk;
    int          n_fail;

    shift_exec_stage_if bus ();

    shift_exec_stage dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .bus      (bus),
        .op_count (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [15:0] d,
                         input logic [3:0] c, input logic [2:0] t);
        bus.in_valid = v;
        bus.in_op    = op;
        bus.in_data  = d;
        bus.in_cnt   = c;
        bus.in_tag   = t;
    endtask

    // One isolated op with out_ready high: accept edge, then result on the following edge.
    task automatic run1(input string tag, input logic [1:0] op, input logic [15:0] d,
                        input logic [3:0] c, input logic [2:0] t,
                        input logic [15:0] exp, input logic expz);
        drive(1'b1, op, d, c, t);
        bus.out_ready = 1'b1;
        #1;
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        tick();
        drive(1'b0, 2'b00, 16'h0, 4'h0, 3'h0);
        chk({tag, "_lat1"}, 32'(bus.out_valid), 32'd0);
        tick();
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_result"}, 32'(bus.out_result), 32'(exp));
        chk({tag, "_tag"}, 32'(bus.out_tag), 32'(t));
        chk({tag, "_zero"}, 32'(bus.out_zero), 32'(expz));
        tick();
        chk({tag, "_drain"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        flush  = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 2'b00, 16'h0, 4'h0, 3'h0);
        tick();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_result", 32'(bus.out_result), 32'd0);
        chk("rst_out_tag", 32'(bus.out_tag), 32'd0);
        chk("rst_out_zero", 32'(bus.out_zero), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        run1("rol1", OP_ROL, 16'h8001, 4'd1, 3'd1, 16'h0003, 1'b0);
        run1("ror1", OP_ROR, 16'h0001, 4'd1, 3'd2, 16'h8000, 1'b0);
        run1("sll4", OP_SLL, 16'hFFFF, 4'd4, 3'd3, 16'hFFF0, 1'b0);
        run1("srl15", OP_SRL, 16'h8000, 4'd15, 3'd4, 16'h0001, 1'b0);
        run1("rol0", OP_ROL, 16'hA5C3, 4'd0, 3'd5, 16'hA5C3, 1'b0);
        run1("sll0", OP_SLL, 16'hA5C3, 4'd0, 3'd6, 16'hA5C3, 1'b0);
        run1("ror0", OP_ROR, 16'hA5C3, 4'd0, 3'd7, 16'hA5C3, 1'b0);
        run1("srl0", OP_SRL, 16'hA5C3, 4'd0, 3'd0, 16'hA5C3, 1'b0);
        run1("sll_zero", OP_SLL, 16'h8000, 4'd1, 3'd2, 16'h0000, 1'b1);
        chk("count_single", 32'(op_count), 32'd9);

        // Streaming: ROL 0x0001 by i gives 1<<i, results expected on consecutive edges.
        for (int i = 0; i < 10; i++) begin
            if (i < 8) drive(1'b1, OP_ROL, 16'h0001, 4'(i), 3'(i));
            else drive(1'b0, 2'b00, 16'h0, 4'h0, 3'h0);
            #1;
            if (i < 8) chk("b2b_in_ready", 32'(bus.in_ready), 32'd1);
            tick();
            if (i >= 1 && i <= 8) begin
                chk("b2b_valid", 32'(bus.out_valid), 32'd1);
                chk("b2b_result", 32'(bus.out_result), 32'(16'h0001 << (i - 1)));
                chk("b2b_tag", 32'(bus.out_tag), 32'((i - 1) % 8));
            end
        end
        chk("b2b_drain", 32'(bus.out_valid), 32'd0);
        chk("b2b_count", 32'(op_count), 32'd17);

        // Backpressure: two ops fill S1/S2, the third stays refused.
        bus.out_ready = 1'b0;
        drive(1'b1, OP_SLL, 16'h0003, 4'd2, 3'd5);
        tick();
        drive(1'b1, OP_SRL, 16'hF000, 4'd4, 3'd6);
        #1;
        chk("bp_ready_b", 32'(bus.in_ready), 32'd1);
        tick();
        drive(1'b1, OP_ROR, 16'h00F0, 4'd4, 3'd7);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_result", 32'(bus.out_result), 32'h000C);
            chk("bp_tag", 32'(bus.out_tag), 32'd5);
            tick();
        end
        drive(1'b0, 2'b00, 16'h0, 4'h0, 3'h0);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_b_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_b_result", 32'(bus.out_result), 32'h0F00);
        chk("bp_b_tag", 32'(bus.out_tag), 32'd6);
        tick();
        chk("bp_drain", 32'(bus.out_valid), 32'd0);
        chk("bp_count", 32'(op_count), 32'd19);

        // Flush with both stages occupied and a new op on the input.
        bus.out_ready = 1'b0;
        drive(1'b1, OP_ROL, 16'h1111, 4'd1, 3'd1);
        tick();
        drive(1'b1, OP_ROL, 16'h2222, 4'd1, 3'd2);
        tick();
        chk("fl_full", 32'(bus.out_valid), 32'd1);
        drive(1'b1, OP_ROL, 16'h3333, 4'd1, 3'd3);
        flush = 1'b1;
        #1;
        chk("fl_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        flush = 1'b0;
        drive(1'b0, 2'b00, 16'h0, 4'h0, 3'h0);
        chk("fl_valid", 32'(bus.out_valid), 32'd0);
        chk("fl_count", 32'(op_count), 32'd19);
        run1("fl_after", OP_ROL, 16'h1234, 4'd4, 3'd4, 16'h2341, 1'b0);
        chk("fl_count2", 32'(op_count), 32'd20);

        // Asynchronous reset while the pipe holds results.
        drive(1'b1, OP_SRL, 16'h00FF, 4'd4, 3'd1);
        tick();
        drive(1'b1, OP_SRL, 16'h0FF0, 4'd4, 3'd2);
        tick();
        drive(1'b0, 2'b00, 16'h0, 4'h0, 3'h0);
        chk("ar_pre_valid", 32'(bus.out_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(bus.out_valid), 32'd0);
        chk("ar_count", 32'(op_count), 32'd0);
        #1;
        rst_n = 1'b1;
        run1("ar_after", OP_ROR, 16'h0003, 4'd1, 3'd3, 16'h8001, 1'b0);
        chk("ar_count2", 32'(op_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
